// File: rtl/act_pkg.sv
// Shared definitions for the activation-unit scheduler: function select
// encodings, operand width and the tag carried alongside each issued operand.
package act_pkg;

    localparam logic ACT_FUNC_SIGMOID = 1'b0;
    localparam logic ACT_FUNC_TANH    = 1'b1;

    // Q3.5 operand / result width
    localparam int ACT_DW = 8;

    // Wide enough for the largest supported requester count (8)
    localparam int ACT_ID_W = 3;

    typedef struct packed {
        logic [ACT_ID_W-1:0] id;
        logic                func;
    } act_tag_t;

endpackage

// File: rtl/act_resp_fifo.sv
// Response FIFO for the activation scheduler. Synchronous push/pop with an
// occupancy count; push and pop may coincide at any occupancy, including full.
module act_resp_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             full;

    assign do_pop = pop && (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign dout   = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap at DEPTH explicitly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Upstream credits must never let a push land on a full, non-draining FIFO
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));

endmodule

// File: rtl/act_unit_scheduler.sv
// Shares one pipelined sigmoid/tanh unit among NUM_REQ requesters using
// round-robin arbitration, a fixed-latency tag pipeline and a credit-guarded
// response FIFO. Results return in issue order with requester id and function.
// Optional build macro ACT_SCHED_STATS_EN adds stat_issued / stat_stall
// saturating counters.
module act_unit_scheduler
    import act_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ACT_LAT   = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [ACT_DW*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_func,
    output logic                         act_valid,
    output logic [ACT_DW-1:0]            act_x,
    output logic                         act_func,
    input  logic [ACT_DW-1:0]            act_y,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ACT_DW-1:0]            resp_data,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic                         resp_func
`ifdef ACT_SCHED_STATS_EN
    ,
    output logic [15:0]                  stat_issued,
    output logic [15:0]                  stat_stall
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(OUT_DEPTH) + 1;
    localparam int IW  = CW + 1;
    localparam int TW  = $bits(act_tag_t);
    localparam int FW  = ACT_DW + TW;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    idx;
    logic              any_valid;
    logic              can_issue;
    logic              issue;
    logic [ACT_DW-1:0] last_x;
    logic              last_func;
    act_tag_t          new_tag;

    logic [ACT_LAT-1:0] stg_valid;
    act_tag_t           stg_tag [ACT_LAT];
    logic [IW-1:0]      inflight;

    logic [CW-1:0]      fifo_count;
    logic [FW-1:0]      fifo_dout;
    act_tag_t           head_tag;
    logic               pop;

    // Round-robin search for the first valid requester starting at rr_ptr
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % 32'(NUM_REQ));
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    // Credits: every issued operand still in the tag pipeline or the FIFO
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ACT_LAT; i++) begin
            inflight = inflight + IW'(stg_valid[i]);
        end
    end

    assign can_issue = (inflight + IW'(fifo_count)) < IW'(OUT_DEPTH);
    assign issue     = reset && any_valid && can_issue;

    // Accept and operand steering; act_x/act_func hold their last value when idle
    always_comb begin
        req_ready    = '0;
        new_tag.id   = ACT_ID_W'(grant);
        new_tag.func = req_func[grant];
        act_valid    = issue;
        act_x        = last_x;
        act_func     = last_func;
        if (issue) begin
            req_ready[grant] = 1'b1;
            act_x            = req_data[ACT_DW*grant +: ACT_DW];
            act_func         = req_func[grant];
        end
    end

    // Arbitration pointer and held operand registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            last_x    <= '0;
            last_func <= ACT_FUNC_SIGMOID;
        end else if (issue) begin
            rr_ptr    <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            last_x    <= act_x;
            last_func <= act_func;
        end
    end

    // Tag pipeline aligned to the activation unit latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_valid <= '0;
            for (int unsigned i = 0; i < ACT_LAT; i++) begin
                stg_tag[i] <= '0;
            end
        end else begin
            stg_valid[0] <= issue;
            stg_tag[0]   <= new_tag;
            for (int unsigned i = 1; i < ACT_LAT; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_tag[i]   <= stg_tag[i-1];
            end
        end
    end

    assign pop = resp_valid && resp_ready;

    act_resp_fifo #(
        .WIDTH (FW),
        .DEPTH (OUT_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (stg_valid[ACT_LAT-1]),
        .din   ({act_y, stg_tag[ACT_LAT-1]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign head_tag   = act_tag_t'(fifo_dout[TW-1:0]);
    assign resp_valid = (fifo_count != '0);
    assign resp_data  = fifo_dout[FW-1 -: ACT_DW];
    assign resp_id    = IDW'(head_tag.id);
    assign resp_func  = head_tag.func;

`ifdef ACT_SCHED_STATS_EN
    // Saturating counters of issues and of credit-stalled request cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if ((|req_valid) && !can_issue && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_act_unit_scheduler.sv
// Self-checking bench for act_unit_scheduler (NUM_REQ=4, ACT_LAT=2,
// OUT_DEPTH=4) with an activation model y = x + 1.
module tb_act_unit_scheduler;

    localparam int NR    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [3:0]  req_func;
    logic        act_valid;
    logic [7:0]  act_x;
    logic        act_func;
    logic [7:0]  act_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        resp_func;
`ifdef ACT_SCHED_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stall;
`endif

    int compared   = 0;
    int mismatched = 0;

    act_unit_scheduler #(
        .NUM_REQ   (NR),
        .ACT_LAT   (LAT),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_func   (req_func),
        .act_valid  (act_valid),
        .act_x      (act_x),
        .act_func   (act_func),
        .act_y      (act_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_func  (resp_func)
`ifdef ACT_SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Activation unit model: y = x + 1, LAT cycles after the operand
    logic [7:0] ypipe [LAT];
    always @(posedge clk) begin
        ypipe[0] <= act_x + 8'd1;
        for (int i = 1; i < LAT; i++) ypipe[i] <= ypipe[i-1];
    end
    assign act_y = ypipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference model: outstanding-credit count, issue-ordered expectation queue
    typedef struct {
        logic [7:0] data;
        int         id;
        logic       func;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         m_rr     = 0;
    int         m_out    = 0;
    int         cyc      = 0;
    logic [7:0] m_lastx  = 8'h00;
    logic       m_lastf  = 1'b0;
    int         m_issued = 0;
    int         m_stall  = 0;

    always @(negedge clk) begin : model
        int         g;
        bit         found;
        bit         can;
        bit         exp_rv;
        logic [3:0] er;
        logic [7:0] ex;
        logic       ef;
        cyc++;
        if (!reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_act_valid", act_valid, 0);
            chk("rst_act_x", act_x, 0);
            chk("rst_act_func", act_func, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_resp_func", resp_func, 0);
            q.delete();
            m_rr = 0; m_out = 0; m_lastx = 8'h00; m_lastf = 1'b0;
            m_issued = 0; m_stall = 0;
        end else begin
            found = 0; g = 0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (!found && req_valid[i]) begin found = 1; g = i; end
            end
            can = (m_out < DEPTH);
            er  = (found && can) ? 4'(1 << g) : 4'b0000;
            ex  = (found && can) ? req_data[8*g +: 8] : m_lastx;
            ef  = (found && can) ? req_func[g] : m_lastf;
            chk("req_ready", req_ready, er);
            chk("act_valid", act_valid, found && can);
            chk("act_x", act_x, ex);
            chk("act_func", act_func, ef);
            exp_rv = (q.size() > 0) && (q[0].due <= cyc);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                chk("resp_data", resp_data, q[0].data);
                chk("resp_id", resp_id, q[0].id);
                chk("resp_func", resp_func, q[0].func);
            end
            if (exp_rv && resp_ready) begin
                void'(q.pop_front());
                m_out--;
            end
            if ((|req_valid) && !can) m_stall++;
            if (found && can) begin
                q.push_back('{ex + 8'd1, g, ef, cyc + LAT + 1});
                m_out++;
                m_issued++;
                m_rr    = (g + 1) % NR;
                m_lastx = ex;
                m_lastf = ef;
            end
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] func;
        logic [7:0] base;
        logic [3:0] exp_ready;
        logic [7:0] exp_x;
        logic       exp_func;
    } vec_t;

    vec_t       vecs [13];
    int         acc;
    int         lat;
    bit         got;
    logic [3:0] acc_v;

    initial begin
        // requester i presents operand base+i
        vecs[0]  = '{4'b1111, 4'b1010, 8'h10, 4'b0001, 8'h10, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1010, 8'h20, 4'b0010, 8'h21, 1'b1};
        vecs[2]  = '{4'b1111, 4'b1010, 8'h30, 4'b0100, 8'h32, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1010, 8'h40, 4'b1000, 8'h43, 1'b1};
        vecs[4]  = '{4'b1010, 4'b0000, 8'h50, 4'b0010, 8'h51, 1'b0};
        vecs[5]  = '{4'b1010, 4'b1111, 8'h60, 4'b1000, 8'h63, 1'b1};
        vecs[6]  = '{4'b1010, 4'b1111, 8'h70, 4'b0010, 8'h71, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 8'h80, 4'b0000, 8'h71, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0001, 8'h90, 4'b0001, 8'h90, 1'b1};
        vecs[9]  = '{4'b0100, 4'b0000, 8'hA0, 4'b0100, 8'hA2, 1'b0};
        vecs[10] = '{4'b1001, 4'b1000, 8'hB0, 4'b1000, 8'hB3, 1'b1};
        vecs[11] = '{4'b0110, 4'b0100, 8'hC0, 4'b0010, 8'hC1, 1'b0};
        vecs[12] = '{4'b1110, 4'b0010, 8'hD0, 4'b0100, 8'hD2, 1'b0};

        reset = 1'b0; req_valid = '0; req_data = '0; req_func = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Table: arbitration order and operand steering from reset
        for (int r = 0; r < 13; r++) begin
            @(posedge clk); #1;
            reset     = 1'b1;
            req_valid = vecs[r].valid;
            req_func  = vecs[r].func;
            for (int i = 0; i < NR; i++) req_data[8*i +: 8] = vecs[r].base + 8'(i);
            #3;
            chk("tbl_ready", req_ready, vecs[r].exp_ready);
            chk("tbl_act_valid", act_valid, |vecs[r].exp_ready);
            chk("tbl_act_x", act_x, vecs[r].exp_x);
            chk("tbl_act_func", act_func, vecs[r].exp_func);
        end
        @(posedge clk); #1; req_valid = '0;
        repeat (6) @(posedge clk);

        // Single request from requester 2: response LAT+1 cycles later
        @(posedge clk); #1;
        req_valid = 4'b0100; req_data[23:16] = 8'h20; req_func = 4'b0100;
        #3;
        chk("single_ready", req_ready, 4'b0100);
        chk("single_act_valid", act_valid, 1);
        chk("single_act_x", act_x, 8'h20);
        got = 0; lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = '0;
            #3;
            if (!got && resp_valid) begin
                got = 1; lat = k;
                chk("single_data", resp_data, 8'h21);
                chk("single_id", resp_id, 2);
                chk("single_func", resp_func, 1);
            end
        end
        chk("single_latency", lat, LAT + 1);

        // Consumer stalled: exactly DEPTH accepts, then one pop frees one credit
        resp_ready = 1'b0; acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001; req_data[7:0] = 8'h50 + 8'(acc);
            #3;
            if (req_ready[0]) acc++;
        end
        chk("stall_accepts", acc, DEPTH);
        chk("stall_ready", req_ready, 0);
        @(posedge clk); #1; resp_ready = 1'b1; #3;
        chk("pop_same_cycle", req_ready, 0);
        @(posedge clk); #1; resp_ready = 1'b0; #3;
        chk("credit_return", req_ready, 4'b0001);
        @(posedge clk); #1; req_data[7:0] = 8'h55; #3;
        chk("stall_again", req_ready, 0);

        // Reset with work outstanding: outputs clear at once, nothing stale later
        @(posedge clk); #1; reset = 1'b0; #1;
        chk("mid_rst_act_valid", act_valid, 0);
        chk("mid_rst_act_x", act_x, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_data", resp_data, 0);
        chk("mid_rst_resp_id", resp_id, 0);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1; resp_ready = 1'b1; req_valid = 4'b1111; req_func = '0;
        req_data = {8'h63, 8'h62, 8'h61, 8'h60};
        #3;
        chk("post_rst_grant", req_ready, 4'b0001);
        chk("post_rst_act_x", act_x, 8'h60);
        @(posedge clk); #1; req_valid = '0; #3;
        chk("post_rst_empty1", resp_valid, 0);
        @(posedge clk); #4;
        chk("post_rst_empty2", resp_valid, 0);
        @(posedge clk); #4;
        chk("post_rst_resp", resp_valid, 1);
        chk("post_rst_data", resp_data, 8'h61);

        // Randomized traffic checked by the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_v = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_v[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                        req_func[i]        = 1'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (((c / 200) % 3) == 2) resp_ready = ($urandom_range(0, 7) == 0);
            else                      resp_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1; req_valid = '0; resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #4;
        chk("drain_queue", q.size(), 0);
        chk("drain_resp_valid", resp_valid, 0);
`ifdef ACT_SCHED_STATS_EN
        chk("stat_issued", stat_issued, m_issued);
        chk("stat_stall", stat_stall, m_stall);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
